// File: rtl/mmul_sequencer.sv
// Control sequencer for one NxN systolic matrix-multiply pass:
// clear accumulators, inject rows, wait out the pipeline, drain results.
module mmul_sequencer #(
   parameter int N         = 4,
   parameter int LATENCY   = 11,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   clear_acc,
   output logic                   dp_enable,
   output logic                   in_valid,
   output logic [$clog2(N)-1:0]   in_row,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(N)-1:0]   out_row,
   output logic [CNT_WIDTH-1:0]   pass_count
);

   localparam int RW = $clog2(N);
   localparam int WW = $clog2(LATENCY + 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_WAIT,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [RW-1:0]          r_row;
   logic [WW-1:0]          r_wait;
   logic [CNT_WIDTH-1:0]   r_pass;
   logic                   w_row_last;
   logic                   w_wait_last;

   assign w_row_last  = (r_row == ROW_LAST);
   assign w_wait_last = (r_wait == WAIT_LAST);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_CLEAR;
         S_CLEAR: w_next = S_LOAD;
         S_LOAD:  if (w_row_last) w_next = S_WAIT;
         S_WAIT:  if (w_wait_last) w_next = S_DRAIN;
         S_DRAIN: if (out_ready && w_row_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_wait  <= '0;
         r_pass  <= '0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            S_LOAD:  r_row <= w_row_last ? '0 : r_row + RW'(1);
            S_DRAIN: begin
               if (out_ready)
                  r_row <= w_row_last ? '0 : r_row + RW'(1);
            end
            default: r_row <= '0;
         endcase
         if (r_state == S_WAIT)
            r_wait <= r_wait + WW'(1);
         else
            r_wait <= '0;
         if (r_state == S_DONE)
            r_pass <= r_pass + CNT_WIDTH'(1);
      end
   end

   // A stalled consumer freezes the whole datapath in DRAIN.
   always_comb begin
      busy      = (r_state != S_IDLE);
      done      = 1'b0;
      clear_acc = 1'b0;
      dp_enable = 1'b0;
      in_valid  = 1'b0;
      in_row    = '0;
      out_valid = 1'b0;
      out_row   = '0;
      unique case (r_state)
         S_CLEAR: begin
            clear_acc = 1'b1;
            dp_enable = 1'b1;
         end
         S_LOAD: begin
            dp_enable = 1'b1;
            in_valid  = 1'b1;
            in_row    = r_row;
         end
         S_WAIT:  dp_enable = 1'b1;
         S_DRAIN: begin
            dp_enable = out_ready;
            out_valid = 1'b1;
            out_row   = r_row;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign pass_count = r_pass;

endmodule

// File: tb/tb_mmul_sequencer.sv
// Directed bench for mmul_sequencer: default array plus an
// N=2 / LATENCY=1 / CNT_WIDTH=2 instance.
module tb_mmul_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start1 = 1'b0;
   logic ready1 = 1'b1;
   logic start2 = 1'b0;
   logic ready2 = 1'b1;

   logic busy1, done1, clr1, en1, iv1, ov1;
   logic [1:0] ir1, or1;
   logic [15:0] pc1;
   logic busy2, done2, clr2, en2, iv2, ov2;
   logic [0:0] ir2, or2;
   logic [1:0] pc2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mmul_sequencer dut1 (
      .clk(clk), .reset(reset), .start(start1),
      .busy(busy1), .done(done1), .clear_acc(clr1),
      .dp_enable(en1), .in_valid(iv1), .in_row(ir1),
      .out_valid(ov1), .out_ready(ready1), .out_row(or1),
      .pass_count(pc1)
   );

   mmul_sequencer #(.N(2), .LATENCY(1), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2),
      .busy(busy2), .done(done2), .clear_acc(clr2),
      .dp_enable(en2), .in_valid(iv2), .in_row(ir2),
      .out_valid(ov2), .out_ready(ready2), .out_row(or2),
      .pass_count(pc2)
   );

   wire [9:0] v1 = {busy1, done1, clr1, en1, iv1, ir1, ov1, or1};
   wire [7:0] v2 = {busy2, done2, clr2, en2, iv2, ir2, ov2, or2};

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start1 = 1'b0;
      start2 = 1'b0;
      ready1 = 1'b1;
      ready2 = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // Hand schedule, start at cycle 0, k stall cycles from cycle 18.
   function automatic logic [9:0] exp1(int c, int k);
      int dc = 21 + k;
      logic b, d, cl, en, iv, ov;
      logic [1:0] ir, orw;
      b  = (c >= 1 && c <= dc);
      d  = (c == dc);
      cl = (c == 1);
      iv = (c >= 2 && c <= 5);
      ir = iv ? 2'(c - 2) : 2'd0;
      ov = (c >= 17 && c <= 20 + k);
      if (!ov || c <= 17) orw = 2'd0;
      else if (c <= 18 + k) orw = 2'd1;
      else orw = 2'(c - 17 - k);
      en = (c >= 1 && c < dc && !(c >= 18 && c <= 17 + k));
      return {b, d, cl, en, iv, ir, ov, orw};
   endfunction

   function automatic logic [7:0] exp2(int c);
      logic b, d, cl, en, iv, ov;
      logic [0:0] ir, orw;
      b  = (c >= 1 && c <= 7);
      d  = (c == 7);
      cl = (c == 1);
      en = (c >= 1 && c <= 6);
      iv = (c >= 2 && c <= 3);
      ir = iv ? 1'(c - 2) : 1'b0;
      ov = (c >= 5 && c <= 6);
      orw = ov ? 1'(c - 5) : 1'b0;
      return {b, d, cl, en, iv, ir, ov, orw};
   endfunction

   task automatic run_pass(int id, int k, bit xs, int last, int base);
      for (int c = 0; c <= last; c++) begin
         start1 = (c == 0) ||
                  (xs && (c == 3 || c == 10 || c == 21 || c == 23));
         ready1 = !(c >= 18 && c <= 17 + k);
         #1;
         chk($sformatf("t%0d_ctl_c%0d", id, c), 32'(v1), 32'(exp1(c, k)));
         chk($sformatf("t%0d_pc_c%0d", id, c), 32'(pc1),
             32'(base + ((c > 21 + k) ? 1 : 0)));
         step();
      end
      start1 = 1'b0;
      ready1 = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("rst_ctl", 32'(v1), 32'd0);
      chk("rst_pc", 32'(pc1), 32'd0);
      chk("rst_ctl2", 32'(v2), 32'd0);

      run_pass(1, 0, 1'b0, 22, 0);

      do_reset();
      run_pass(2, 3, 1'b0, 25, 0);

      do_reset();
      run_pass(3, 0, 1'b1, 23, 0);
      #1;
      chk("t3_clear24", 32'({busy1, clr1, en1}), 32'h7);
      chk("t3_pc24", 32'(pc1), 32'd1);

      do_reset();
      for (int c = 0; c <= 10; c++) begin
         start1 = (c == 0);
         reset = (c == 10);
         #1;
         chk($sformatf("t4_ctl_c%0d", c), 32'(v1), 32'(exp1(c, 0)));
         step();
      end
      reset = 1'b0;
      chk("t4_abort_ctl", 32'(v1), 32'd0);
      chk("t4_abort_pc", 32'(pc1), 32'd0);
      run_pass(4, 0, 1'b0, 22, 0);

      do_reset();
      for (int p = 0; p < 5; p++) begin
         for (int c = 0; c <= 8; c++) begin
            start2 = (c == 0);
            #1;
            chk($sformatf("t5_p%0d_c%0d", p, c), 32'(v2), 32'(exp2(c)));
            chk($sformatf("t6_pc_p%0d_c%0d", p, c), 32'(pc2),
                32'((c >= 8) ? (p + 1) % 4 : p % 4));
            step();
         end
      end
      start2 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmul_sequencer.md
Name: mmul_sequencer

Overview:
- Top-level control FSM for one N×N matrix multiply pass through the systolic datapath: input skew buffer, PE grid, output deskew buffer.
- Clears the PE accumulators, then injects N input rows.
- Waits a fixed pipeline latency, then presents the N deskewed result rows to a downstream consumer with valid/ready backpressure.
- Drives the shared `enable` of every datapath stage. Stalling the consumer therefore freezes the whole array coherently.

Parameters:
- N, 4, array dimension; rows injected and rows collected per pass (≥2).
- LATENCY, 11, cycles from the last input row injected to the first deskewed result row valid at the output buffer (≥1). Default is 3N-1.
- CNT_WIDTH, 16, width of the completed-pass counter.

Ports:
- clk, input, 1, clock; all state updates on its rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request a pass; sampled only in IDLE.
- busy, output, 1, high whenever state ≠ IDLE.
- done, output, 1, one-cycle pulse in the DONE state.
- clear_acc, output, 1, accumulator clear to the PEs; high only in CLEAR.
- dp_enable, output, 1, enable to skew buffer, PE grid and output buffer.
- in_valid, output, 1, high while an input row is injected.
- in_row, output, clog2(N), index of the row being injected.
- out_valid, output, 1, a result row is present on the output buffer.
- out_ready, input, 1, consumer accepts the result row this cycle.
- out_row, output, clog2(N), index of the presented result row.
- pass_count, output, CNT_WIDTH, number of completed passes; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (synchronous, active-high): state = IDLE, all counters 0, pass_count = 0.
  - All outputs are 0 in the cycle after reset is sampled.
  - Reset asserted in any state aborts the pass immediately; no done pulse is issued.
- All outputs are registered or decoded from registered state; there is no combinational path from start to any output.
  - Exception: dp_enable in DRAIN is combinational from out_ready.
- State flow: IDLE → CLEAR → LOAD → WAIT → DRAIN → DONE → IDLE.
- IDLE:
  - All control outputs are 0.
  - start = 1 → CLEAR next cycle.
  - start in any other state is ignored; it is not queued.
- CLEAR (1 cycle): clear_acc = 1, dp_enable = 1 → LOAD.
- LOAD (N cycles): in_valid = 1, dp_enable = 1, in_row counts 0..N-1. After in_row = N-1 → WAIT.
- WAIT (LATENCY cycles): dp_enable = 1, in_valid = 0, out_valid = 0. After the LATENCY-th cycle → DRAIN.
- DRAIN: out_valid = 1, and out_row starts at 0.
  - Beat accepted when out_valid & out_ready:
    - dp_enable = 1 in that cycle.
    - out_row increments next cycle.
    - Accepting row N-1 → DONE.
  - out_ready = 0:
    - dp_enable = 0, so the entire datapath holds.
    - out_row and state hold.
    - out_valid stays 1 and data stays stable.
  - Arbitrarily long stalls are legal.
- DONE (1 cycle): done = 1, dp_enable = 0, pass_count increments (wrapping) → IDLE.
- start high in DONE is ignored. A new pass needs start sampled in IDLE, so the minimum gap between done and the next CLEAR is 2 cycles.
- Counter widths: row counter clog2(N); wait counter clog2(LATENCY+1). No counter overflows within a legal pass.
- Pass duration without stalls: 1 (CLEAR) + N + LATENCY + N + 1 (DONE) cycles after the start cycle.

Test Plan (N=4, LATENCY=11 unless stated):
1. Reset, then start=1 at cycle 0 with out_ready tied 1.
   - clear_acc at cycle 1.
   - in_valid cycles 2–5 with in_row 0,1,2,3.
   - out_valid cycles 17–20 with out_row 0..3.
   - done at cycle 21 only; busy 1..21; pass_count = 1 at cycle 22.
2. Same as test 1, but out_ready = 0 for cycles 18–20.
   - out_row holds at 1 and dp_enable = 0 in cycles 18–20.
   - Rows 1–3 are accepted in cycles 21–23.
   - done at cycle 24.
3. start pulses during LOAD, WAIT and DONE.
   - Ignored: exactly one pass and one done.
   - A start at cycle 23 (IDLE) begins a new CLEAR at cycle 24.
4. reset asserted at cycle 10, in WAIT.
   - At cycle 11: busy = 0, dp_enable = 0, no done pulse, pass_count = 0.
   - A following start runs a full correct pass.
5. N=2, LATENCY=1, out_ready = 1.
   - in_valid cycles 2–3, out_valid cycles 5–6, done at cycle 7.
6. CNT_WIDTH=2, 5 back-to-back passes.
   - pass_count reads 1,2,3,0,1 after each done.
